pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register for the exception-capable CPU datapath. It replaces the fixed per-stage latches with one generic block. Features: valid/ready handshake, an optional skid entry, and a flush that inserts a bubble while keeping selected payload bits (e.g. PC+8, for EPC) from the incoming word. It sits between any two pipeline stages (D→E, E→M, M→W) and also provides a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- DW, 128: payload width in bits.
- KEEP_MASK, {DW{1'b0}}: payload bits loaded from in_data on flush; all other bits are zeroed.
- SKID, 0: 0 = single register, combinational ready path; 1 = adds a skid entry, registered in_ready.
- CNT_W, 16: stall counter width.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  upstream word present.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  DW  upstream payload (instr, operands, imm, pc8, cause, wa packed by the caller).
- out_valid  out  1  downstream word present.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DW  registered payload.
- flush  in  1  synchronous bubble insertion (exception / branch clear).
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid && !out_ready.
- stall_clr  in  1  synchronous clear of stall_cnt.

## Operation
- Transfers: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- SKID=0: one entry (main). in_ready = (!main_valid || out_ready) && !flush. On accept, main ← in_data, main_valid ← 1. If consumed and nothing accepted, main_valid ← 0 and data holds.
- SKID=1: entries main and skid. in_ready = !skid_valid && !flush, taken from a register, with no combinational path from out_ready.
  - Accept while main is full and not consumed: the word goes to skid.
  - Main consumed while skid is full: main ← skid, skid_valid ← 0, same cycle.
  - Order is strictly FIFO.
- Flush overrides every transfer in the same cycle:
  - main_valid ← 0, skid_valid ← 0.
  - main_data ← in_data & KEEP_MASK, whatever the value of in_valid.
  - The upstream word is not accepted (in_ready = 0).
- stall_cnt increments every cycle with out_valid && !out_ready and saturates at 2^CNT_W−1.
  - stall_clr has priority over increment.
  - Flush does not clear stall_cnt.
- out_data is always main_data. Consumers gate on out_valid, except the exception unit, which reads the kept bits of a flushed bubble.

## Timing
- Reset (asynchronous assert, released synchronously by the top level) sets:
  - out_valid = 0, out_data = 0, skid cleared, stall_cnt = 0.
  - in_ready = 0 while rst is high. After release: 1 (SKID=0, !flush) or 1 from the first clock (SKID=1).
- Latency: 1 cycle from accept to out_valid with an empty stage. The skid adds no latency, only buffering.
- Throughput: 1 word/cycle in both modes while out_ready is held at 1.
- Reset mid-transfer: all in-flight words are discarded and no partial state survives.
- Simultaneous flush and out_ready: the current main word is still consumed this cycle, because out_valid was 1 before the edge. The next cycle shows a bubble.
- Simultaneous stall_clr and a stall cycle: stall_cnt = 0 next cycle.
- In SKID=1, in_ready deasserts the cycle after skid fills, and reasserts the cycle after skid drains.

## Structure
- Shared CPU package holds:
  - Payload field offsets (PC8_LSB, INSTR_LSB, CAUSE_LSB, WA_LSB).
  - Pre-built KEEP_MASK constants per stage, e.g. KEEP_PC8.
- One natural sub-module: pipe_skid_entry (valid + data register with load/clear), instanced once for main and once for skid when SKID=1, via a generate block.
- The stall counter stays inline.

## Test plan
- Reset mid-stream: SKID=1, both entries full, assert rst asynchronously → out_valid=0, out_data=0, stall_cnt=0 immediately, before any clock edge.
- Streaming: SKID=0, in_valid=1 with data 0x1..0x8 on consecutive cycles, out_ready=1 → out_data is 0x1..0x8, one cycle later, with no gaps.
- Backpressure with skid: SKID=1, push 0xA, 0xB, 0xC with out_ready=0 →
  - 0xA sits in main, 0xB in skid.
  - in_ready drops after 0xB, so 0xC is held upstream.
  - After out_ready=1: output order 0xA, 0xB, 0xC.
  - stall_cnt equals the number of stalled cycles.
- Flush with keep: KEEP_MASK = pc8 field, in_data pc8=0x00003008, other fields nonzero, flush=1 → next cycle out_valid=0, out_data pc8=0x00003008, all other bits 0. Both entries empty.
- Flush vs. accept: flush=1 and in_valid=1 in the same cycle → in_ready=0, the word is not stored, and upstream must re-present it.
- Counter saturation and clear: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt=15. Then stall_clr together with a stall → stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_reg_pkg                                                    |
// | Shared CPU payload layout, per-stage keep masks, entry operations.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pipe_stage_reg_pkg;

  localparam int PAYLOAD_W = 128;

  // Payload field layout as packed by the calling stage.
  localparam int PC8_LSB   = 0;
  localparam int PC8_W     = 32;
  localparam int INSTR_LSB = 32;
  localparam int INSTR_W   = 32;
  localparam int CAUSE_LSB = 64;
  localparam int CAUSE_W   = 5;
  localparam int WA_LSB    = 69;
  localparam int WA_W      = 5;

  typedef enum logic [1:0] {
    ENT_HOLD   = 2'd0,
    ENT_LOAD   = 2'd1,
    ENT_DROP   = 2'd2,
    ENT_BUBBLE = 2'd3
  } entry_op_e;

  function automatic logic [PAYLOAD_W-1:0] field_mask(input int lsb, input int width);
    logic [PAYLOAD_W-1:0] m;
    m = '0;
    for (int i = 0; i < PAYLOAD_W; i++) begin
      if (i >= lsb && i < lsb + width) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [PAYLOAD_W-1:0] KEEP_NONE      = '0;
  localparam logic [PAYLOAD_W-1:0] KEEP_PC8       = field_mask(PC8_LSB, PC8_W);
  localparam logic [PAYLOAD_W-1:0] KEEP_PC8_CAUSE = field_mask(PC8_LSB, PC8_W)
                                                  | field_mask(CAUSE_LSB, CAUSE_W);

endpackage
`default_nettype wire

// File: rtl/pipe_skid_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_skid_entry                                                       |
// | One valid+data storage entry driven by a load/drop/bubble command.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pipe_skid_entry
  import pipe_stage_reg_pkg::*;
#(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  entry_op_e     op,
  input  logic [DW-1:0] d,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic          valid_d;
  logic          valid_q;
  logic [DW-1:0] data_d;
  logic [DW-1:0] data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    case (op)
      ENT_LOAD: begin
        valid_d = 1'b1;
        data_d  = d;
      end
      ENT_DROP: valid_d = 1'b0;
      // Bubble: invalid, but the payload still carries the kept bits.
      ENT_BUBBLE: begin
        valid_d = 1'b0;
        data_d  = d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_reg                                                        |
// | Generic valid/ready pipeline register with optional skid entry,       |
// | mask-preserving flush and saturating stall counter.                   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int            DW        = 128,
  parameter logic [DW-1:0] KEEP_MASK = '0,
  parameter int            SKID      = 0,
  parameter int            CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_op_e     main_op;
  logic [DW-1:0] main_d;
  logic          main_valid;
  logic [DW-1:0] main_data;
  logic          main_consume;
  logic          accept;

  assign main_consume = main_valid && out_ready;
  assign accept       = in_valid && in_ready;

  pipe_skid_entry #(.DW(DW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .op    (main_op),
    .d     (main_d),
    .valid (main_valid),
    .data  (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      entry_op_e     skid_op;
      logic          skid_valid;
      logic [DW-1:0] skid_data;
      logic          skid_valid_d;
      logic          ready_d;
      logic          ready_q;

      pipe_skid_entry #(.DW(DW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .op    (skid_op),
        .d     (in_data),
        .valid (skid_valid),
        .data  (skid_data)
      );

      always_comb begin
        main_op = ENT_HOLD;
        main_d  = in_data;
        skid_op = ENT_HOLD;
        if (flush) begin
          main_op = ENT_BUBBLE;
          main_d  = in_data & KEEP_MASK;
          skid_op = ENT_DROP;
        end else if (main_consume && skid_valid) begin
          main_op = ENT_LOAD;
          main_d  = skid_data;
          skid_op = ENT_DROP;
        end else if (accept && (!main_valid || main_consume)) begin
          main_op = ENT_LOAD;
        end else if (accept) begin
          skid_op = ENT_LOAD;
        end else if (main_consume) begin
          main_op = ENT_DROP;
        end
      end

      // Ready tracks the next-cycle skid occupancy so out_ready never reaches in_ready.
      always_comb begin
        skid_valid_d = skid_valid;
        if (skid_op == ENT_LOAD)      skid_valid_d = 1'b1;
        else if (skid_op == ENT_DROP) skid_valid_d = 1'b0;
        ready_d = !skid_valid_d;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_q <= 1'b0;
        else     ready_q <= ready_d;
      end

      assign in_ready = ready_q && !flush;
    end else begin : g_single
      always_comb begin
        main_op = ENT_HOLD;
        main_d  = in_data;
        if (flush) begin
          main_op = ENT_BUBBLE;
          main_d  = in_data & KEEP_MASK;
        end else if (accept) begin
          main_op = ENT_LOAD;
        end else if (main_consume) begin
          main_op = ENT_DROP;
        end
      end

      assign in_ready = (!main_valid || out_ready) && !flush && !rst;
    end
  endgenerate

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (stall_clr)                                   cnt_d = '0;
    else if (main_valid && !out_ready && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign stall_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_stage_reg                                                     |
// | Drives a SKID=0 and a SKID=1 instance against a queue-based model.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int DW = 128;
  localparam logic [DW-1:0] KEEP = KEEP_PC8;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          flush;
  logic          stall_clr;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [DW-1:0] out_data0, out_data1;
  logic [3:0]    stall_cnt0;
  logic [15:0]   stall_cnt1;

  pipe_stage_reg #(.DW(DW), .KEEP_MASK(KEEP), .SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .flush(flush), .stall_cnt(stall_cnt0), .stall_clr(stall_clr)
  );

  pipe_stage_reg #(.DW(DW), .KEEP_MASK(KEEP), .SKID(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .flush(flush), .stall_cnt(stall_cnt1), .stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  // Reference model: each stage is a FIFO of capacity 1 or 2 plus the last payload seen.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] hold0, hold1;
  int            cnt0, cnt1;
  bit            rdy1;
  int            n_checks, n_fail;

  function automatic bit m_rdy0();
    return !flush && (q0.size() == 0 || out_ready);
  endfunction

  function automatic bit m_rdy1();
    return rdy1 && !flush;
  endfunction

  function automatic logic [DW-1:0] m_data0();
    return (q0.size() != 0) ? q0[0] : hold0;
  endfunction

  function automatic logic [DW-1:0] m_data1();
    return (q1.size() != 0) ? q1[0] : hold1;
  endfunction

  task automatic reset_model();
    q0.delete();
    q1.delete();
    hold0 = '0;
    hold1 = '0;
    cnt0  = 0;
    cnt1  = 0;
    rdy1  = 1'b0;
  endtask

  // Advance one clock with the inputs currently driven; returns at the next negedge.
  task automatic step();
    bit a0, a1, c0, c1, s0, s1;
    a0 = in_valid && m_rdy0();
    a1 = in_valid && m_rdy1();
    c0 = (q0.size() != 0) && out_ready;
    c1 = (q1.size() != 0) && out_ready;
    s0 = (q0.size() != 0) && !out_ready;
    s1 = (q1.size() != 0) && !out_ready;
    @(posedge clk);
    if (flush) begin
      q0.delete();
      q1.delete();
      hold0 = in_data & KEEP;
      hold1 = in_data & KEEP;
    end else begin
      if (c0) hold0 = q0.pop_front();
      if (a0) q0.push_back(in_data);
      if (c1) hold1 = q1.pop_front();
      if (a1) q1.push_back(in_data);
    end
    cnt0 = stall_clr ? 0 : ((s0 && cnt0 < 15) ? cnt0 + 1 : cnt0);
    cnt1 = stall_clr ? 0 : ((s1 && cnt1 < 65535) ? cnt1 + 1 : cnt1);
    rdy1 = (q1.size() < 2);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reset_model();
    @(negedge clk);
    n_checks += 4;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b/%b want 0/0", out_valid0, out_valid1);
    end
    if (out_data0 !== '0 || out_data1 !== '0) begin
      n_fail++; $display("FAIL reset_data got %h/%h want 0", out_data0, out_data1);
    end
    if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready got %b/%b want 0/0", in_ready0, in_ready1);
    end
    if (stall_cnt0 !== 4'd0 || stall_cnt1 !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0", stall_cnt0, stall_cnt1);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks += 2;
    if (in_ready0 !== 1'b1) begin
      n_fail++; $display("FAIL release_ready0 got %b want 1", in_ready0);
    end
    if (in_ready1 !== 1'b0) begin
      n_fail++; $display("FAIL release_ready1_preclk got %b want 0", in_ready1);
    end
    step();
    n_checks++;
    if (in_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL release_ready1_postclk got %b want 1", in_ready1);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(k);
      #1;
      n_checks++;
      if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
        n_fail++; $display("FAIL stream_ready k=%0d got %b/%b want 1/1", k, in_ready0, in_ready1);
      end
      step();
      n_checks += 2;
      if (out_valid0 !== 1'b1 || out_data0 !== DW'(k)) begin
        n_fail++; $display("FAIL stream0 k=%0d got v=%b d=%h want v=1 d=%h", k, out_valid0, out_data0, DW'(k));
      end
      if (out_valid1 !== 1'b1 || out_data1 !== DW'(k)) begin
        n_fail++; $display("FAIL stream1 k=%0d got v=%b d=%h want v=1 d=%h", k, out_valid1, out_data1, DW'(k));
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL stream_drain got %b/%b want 0/0", out_valid0, out_valid1);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] words[3];
    logic [DW-1:0] got[$];
    int idx;
    words[0] = 128'hA;
    words[1] = 128'hB;
    words[2] = 128'hC;
    idx = 0;
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      in_valid = 1'b1;
      in_data  = words[idx];
      #1;
      n_checks++;
      if (in_ready1 !== bit'(t < 2)) begin
        n_fail++; $display("FAIL bp_in_ready t=%0d got %b want %b", t, in_ready1, bit'(t < 2));
      end
      if (m_rdy1()) idx++;
      step();
    end
    n_checks += 2;
    if (out_data1 !== words[0]) begin
      n_fail++; $display("FAIL bp_main got %h want %h", out_data1, words[0]);
    end
    if (stall_cnt1 !== 16'd4) begin
      n_fail++; $display("FAIL bp_stall_cnt got %0d want 4", stall_cnt1);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      in_valid = (idx < 3);
      in_data  = (idx < 3) ? words[idx] : '0;
      #1;
      if (out_valid1) got.push_back(out_data1);
      if (in_valid && m_rdy1()) idx++;
      step();
    end
    n_checks++;
    if (got.size() != 3) begin
      n_fail++; $display("FAIL bp_count got %0d want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got[i] !== words[i]) begin
          n_fail++; $display("FAIL bp_order i=%0d got %h want %h", i, got[i], words[i]);
        end
      end
    end
  endtask

  task automatic test_flush_keep();
    logic [DW-1:0] expd;
    expd = 128'h0000_3008;
    out_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    in_data = 128'h1234_5678_9ABC_DEF0_0000_0011_0000_3008;
    flush   = 1'b1;
    #1;
    n_checks++;
    if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready got %b/%b want 0/0", in_ready0, in_ready1);
    end
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks += 2;
    if (out_valid0 !== 1'b0 || out_data0 !== expd) begin
      n_fail++; $display("FAIL flush_keep0 got v=%b d=%h want v=0 d=%h", out_valid0, out_data0, expd);
    end
    if (out_valid1 !== 1'b0 || out_data1 !== expd) begin
      n_fail++; $display("FAIL flush_keep1 got v=%b d=%h want v=0 d=%h", out_valid1, out_data1, expd);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL flush_empty got %b/%b want 0/0", out_valid0, out_valid1);
    end
  endtask

  task automatic test_flush_vs_accept();
    logic [DW-1:0] w;
    w = 128'h5555_0000_0000_0000_0000_0000_0000_7777;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = w;
    flush     = 1'b1;
    #1;
    n_checks++;
    if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
      n_fail++; $display("FAIL fva_ready got %b/%b want 0/0", in_ready0, in_ready1);
    end
    step();
    flush = 1'b0;
    n_checks++;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL fva_not_stored got %b/%b want 0/0", out_valid0, out_valid1);
    end
    #1;
    step();
    n_checks++;
    if (out_valid0 !== 1'b1 || out_data0 !== w || out_valid1 !== 1'b1 || out_data1 !== w) begin
      n_fail++; $display("FAIL fva_represent got %h/%h want %h", out_data0, out_data1, w);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'hFEED;
    step();
    in_valid = 1'b0;
    for (int t = 0; t < 20; t++) step();
    n_checks += 2;
    if (stall_cnt0 !== 4'd15) begin
      n_fail++; $display("FAIL sat_cnt0 got %0d want 15", stall_cnt0);
    end
    if (stall_cnt1 !== 16'd20) begin
      n_fail++; $display("FAIL sat_cnt1 got %0d want 20", stall_cnt1);
    end
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    n_checks++;
    if (stall_cnt0 !== 4'd0 || stall_cnt1 !== 16'd0) begin
      n_fail++; $display("FAIL clr_priority got %0d/%0d want 0/0", stall_cnt0, stall_cnt1);
    end
    step();
    n_checks++;
    if (stall_cnt0 !== 4'd1) begin
      n_fail++; $display("FAIL clr_resume got %0d want 1", stall_cnt0);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 23) == 0;
      stall_clr = ($urandom % 37) == 0;
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      #1;
      n_checks += 2;
      if (in_ready0 !== m_rdy0()) begin
        n_fail++; $display("FAIL rnd_ready0 t=%0d got %b want %b", t, in_ready0, m_rdy0());
      end
      if (in_ready1 !== m_rdy1()) begin
        n_fail++; $display("FAIL rnd_ready1 t=%0d got %b want %b", t, in_ready1, m_rdy1());
      end
      step();
      n_checks += 6;
      if (out_valid0 !== (q0.size() != 0)) begin
        n_fail++; $display("FAIL rnd_valid0 t=%0d got %b want %b", t, out_valid0, q0.size() != 0);
      end
      if (out_data0 !== m_data0()) begin
        n_fail++; $display("FAIL rnd_data0 t=%0d got %h want %h", t, out_data0, m_data0());
      end
      if (int'(stall_cnt0) != cnt0) begin
        n_fail++; $display("FAIL rnd_cnt0 t=%0d got %0d want %0d", t, stall_cnt0, cnt0);
      end
      if (out_valid1 !== (q1.size() != 0)) begin
        n_fail++; $display("FAIL rnd_valid1 t=%0d got %b want %b", t, out_valid1, q1.size() != 0);
      end
      if (out_data1 !== m_data1()) begin
        n_fail++; $display("FAIL rnd_data1 t=%0d got %h want %h", t, out_data1, m_data1());
      end
      if (int'(stall_cnt1) != cnt1) begin
        n_fail++; $display("FAIL rnd_cnt1 t=%0d got %0d want %0d", t, stall_cnt1, cnt1);
      end
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    stall_clr = 1'b0;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int t = 0; t < 3; t++) begin
      in_data = DW'(t + 16'h100);
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (q1.size() != 2 || out_valid1 !== 1'b1) begin
      n_fail++; $display("FAIL mid_prefill got v=%b want 1 (model depth %0d)", out_valid1, q1.size());
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks += 3;
    if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_valid got %b/%b want 0/0", out_valid0, out_valid1);
    end
    if (out_data0 !== '0 || out_data1 !== '0) begin
      n_fail++; $display("FAIL mid_rst_data got %h/%h want 0", out_data0, out_data1);
    end
    if (stall_cnt0 !== 4'd0 || stall_cnt1 !== 16'd0 || in_ready1 !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_cnt got %0d/%0d rdy=%b want 0/0 rdy=0", stall_cnt0, stall_cnt1, in_ready1);
    end
    reset_model();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL mid_post got v=%b rdy=%b want v=0 rdy=1", out_valid1, in_ready1);
    end
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    stall_clr = 1'b0;
    n_checks  = 0;
    n_fail    = 0;
    reset_model();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_keep();
    test_flush_vs_accept();
    test_saturation();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
